multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Main sequencer for the multi-cycle MIPS datapath: one shared memory, one ALU, IR/MDR/A/B/ALUOut regs.
//  Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, driving Moore control strobes per state.
//  Stretches memory states on a ready handshake. Same ALUOp encoding as the single-cycle decoder.
// PARAMETERS
//  MEM_HANDSHAKE  1  1: FETCH/MEMRD/MEMWR hold until MemReady; 0: MemReady ignored, treated as 1
//  STATE_W        4  state register width (12 states used)
// PORTS
//  Clk          in   1  single clock, all state updates on rising edge
//  Reset        in   1  synchronous, active-high
//  Op           in   6  IR[31:26]; sampled in DECODE only
//  MemReady     in   1  memory completes the current read/write this cycle
//  PCWrite      out  1  unconditional PC load
//  PCWriteCond  out  1  PC load if ALU Zero (BEQ)
//  PCWriteCondNe out 1  PC load if !Zero (BNE)
//  IorD         out  1  0: mem addr=PC, 1: mem addr=ALUOut
//  MemRead      out  1  memory read strobe
//  MemWrite     out  1  memory write strobe
//  IRWrite      out  1  load IR (and MDR) from memory
//  MemtoReg     out  1  1: reg write data=MDR, 0: ALUOut
//  RegDst       out  1  1: rd, 0: rt
//  RegWrite     out  1  register file write
//  ALUSrcA      out  1  0: PC, 1: A
//  ALUSrcB      out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  ALUOp        out  4  0000 add,0001 beq-sub,0010 R-type(funct),0100 addi,0101 addiu,0110 andi,
//                       0111 ori,1000 xori,1001 slti,1010 sltiu,1011 bne-sub,1100 jump
//  PCSource     out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
//  IllegalOp    out  1  1-cycle pulse in DECODE on unsupported opcode
//  State        out  STATE_W  current state, debug
// BEHAVIOUR
//  Reset high: next state FETCH, op_q<=0; while Reset=1 every strobe/enable output forced 0.
//  Outputs decoded from state (+op_q); all unlisted outputs 0 in each state. op_q<=Op in DECODE.
//  FETCH(0): IorD=0,MemRead=1,ALUSrcA=0,ALUSrcB=01,ALUOp=0000,PCSource=00;
//   IRWrite=PCWrite=MemReady; ->DECODE when MemReady, else stay (PC/IR untouched while waiting).
//  DECODE(1): ALUSrcA=0,ALUSrcB=11,ALUOp=0000 (branch target into ALUOut). Next by Op:
//   LW/SW->MEMADR; RTYPE->EXEC; BEQ/BNE->BRANCH; J->JUMP;
//   ADDI/ADDIU/ANDI/ORI/XORI/SLTI/SLTIU->IEXEC; NOP(110110)->FETCH; other->FETCH + IllegalOp=1.
//  MEMADR(2): ALUSrcA=1,ALUSrcB=10,ALUOp=0000; ->MEMRD if op_q=LW else MEMWR.
//  MEMRD(3): IorD=1,MemRead=1; ->MEMWB on MemReady, else stay.
//  MEMWB(4): RegDst=0,MemtoReg=1,RegWrite=1; ->FETCH.
//  MEMWR(5): IorD=1,MemWrite=1; ->FETCH on MemReady, else stay.
//  EXEC(6): ALUSrcA=1,ALUSrcB=00,ALUOp=0010; ->ALUWB.  ALUWB(7): RegDst=1,RegWrite=1; ->FETCH.
//  BRANCH(8): ALUSrcA=1,ALUSrcB=00,PCSource=01; BEQ: ALUOp=0001,PCWriteCond=1;
//   BNE: ALUOp=1011,PCWriteCondNe=1; ->FETCH.
//  JUMP(9): PCWrite=1,PCSource=10,ALUOp=1100; ->FETCH.
//  IEXEC(10): ALUSrcA=1,ALUSrcB=10,ALUOp per op_q; ->IWB.  IWB(11): RegDst=0,RegWrite=1; ->FETCH.
//  CPI: R/I-type 4, LW 5, SW 4, BEQ/BNE/J 3, NOP/illegal 2 (MEM_HANDSHAKE=0 or no waits);
//   +1 per MemReady=0 cycle in FETCH/MEMRD/MEMWR.
//  Never MemRead&MemWrite together; never RegWrite in a memory-wait state.
//  Reset mid-instruction (any state, incl. waits): abort, FETCH next cycle, no partial writes after.
//  Unused encodings 12..15: ->FETCH, outputs 0.
// STRUCTURE
//  Package mips_defs: opcode constants (RTYPE,LW,SW,BEQ,BNE,J,ADDI..SLTIU,NOP), ALUOp codes,
//   ALUSrcB/PCSource encodings, state encodings.
//  Sub-module mc_op_decode (combinational): Op -> {class, imm ALUOp, legal}; used by DECODE/IEXEC.
// TESTING
//  Reset 3 cycles, MemReady=1: State=0, all strobes 0 during Reset; FETCH asserts MemRead,PCWrite.
//  RTYPE, MemReady=1 -> states 0,1,6,7,0; ALUOp=0010 in EXEC; RegWrite,RegDst=1 only in ALUWB.
//  LW, MemReady low 2 cycles in MEMRD -> 0,1,2,3,3,3,4,0; MemtoReg=1,RegWrite=1 in MEMWB only.
//  BNE -> 0,1,8,0 with PCWriteCondNe=1,PCSource=01,ALUOp=1011; BEQ same with PCWriteCond,0001.
//  ORI -> IEXEC ALUOp=0111,ALUSrcB=10; Op=111111 -> IllegalOp pulse 1 cycle, back to FETCH, no writes.
//  Reset asserted in MEMWR with MemReady=0 -> MemWrite 0 same cycle, State=0 next edge.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// ---------------------------------------------------------------------------
// mips_defs : shared definitions for the multi-cycle MIPS control sequencer.
//   - opcode constants for every supported instruction
//   - ALUOp, ALUSrcB and PCSource encodings
//   - state encoding (numeric values are visible on the debug State port)
//   - instruction class enum produced by mc_op_decode
//   - ctrl_t bundle of Moore strobes plus ctrl_for_state(), the per-state
//     strobe table used by the top-level sequencer
// ---------------------------------------------------------------------------
package mips_defs;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_NOP   = 6'b110110;

   // ALUOp codes, shared with the single-cycle decoder
   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_BEQ   = 4'b0001;
   localparam logic [3:0] ALU_RTYPE = 4'b0010;
   localparam logic [3:0] ALU_ADDI  = 4'b0100;
   localparam logic [3:0] ALU_ADDIU = 4'b0101;
   localparam logic [3:0] ALU_ANDI  = 4'b0110;
   localparam logic [3:0] ALU_ORI   = 4'b0111;
   localparam logic [3:0] ALU_XORI  = 4'b1000;
   localparam logic [3:0] ALU_SLTI  = 4'b1001;
   localparam logic [3:0] ALU_SLTIU = 4'b1010;
   localparam logic [3:0] ALU_BNE   = 4'b1011;
   localparam logic [3:0] ALU_JUMP  = 4'b1100;

   // ALU B-operand select
   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   // PC source select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_MEMADR = 4'd2,
      ST_MEMRD  = 4'd3,
      ST_MEMWB  = 4'd4,
      ST_MEMWR  = 4'd5,
      ST_EXEC   = 4'd6,
      ST_ALUWB  = 4'd7,
      ST_BRANCH = 4'd8,
      ST_JUMP   = 4'd9,
      ST_IEXEC  = 4'd10,
      ST_IWB    = 4'd11
   } state_e;

   typedef enum logic [3:0] {
      CLS_RTYPE   = 4'd0,
      CLS_LW      = 4'd1,
      CLS_SW      = 4'd2,
      CLS_BEQ     = 4'd3,
      CLS_BNE     = 4'd4,
      CLS_J       = 4'd5,
      CLS_IMM     = 4'd6,
      CLS_NOP     = 4'd7,
      CLS_ILLEGAL = 4'd8
   } op_class_e;

   // fetch_gate marks strobes that only fire once memory reports ready
   typedef struct packed {
      logic       pcwrite;
      logic       fetch_gate;
      logic       pcwritecond;
      logic       pcwritecondne;
      logic       iord;
      logic       memread;
      logic       memwrite;
      logic       irwrite;
      logic       memtoreg;
      logic       regdst;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [3:0] aluop;
      logic [1:0] pcsource;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

   // Moore strobe table: everything not listed for a state stays 0
   function automatic ctrl_t ctrl_for_state(state_e st, op_class_e cls,
                                            logic [3:0] imm_aluop);
      ctrl_t c;
      c = ctrl_t'({CTRL_W{1'b0}});
      case (st)
         ST_FETCH: begin
            c.memread    = 1'b1;
            c.irwrite    = 1'b1;
            c.pcwrite    = 1'b1;
            c.fetch_gate = 1'b1;
            c.alusrcb    = SRCB_FOUR;
            c.aluop      = ALU_ADD;
            c.pcsource   = PCSRC_ALU;
         end
         ST_DECODE: begin
            c.alusrcb = SRCB_IMM_SH;
            c.aluop   = ALU_ADD;
         end
         ST_MEMADR: begin
            c.alusrca = 1'b1;
            c.alusrcb = SRCB_IMM;
            c.aluop   = ALU_ADD;
         end
         ST_MEMRD: begin
            c.iord    = 1'b1;
            c.memread = 1'b1;
         end
         ST_MEMWB: begin
            c.memtoreg = 1'b1;
            c.regwrite = 1'b1;
         end
         ST_MEMWR: begin
            c.iord     = 1'b1;
            c.memwrite = 1'b1;
         end
         ST_EXEC: begin
            c.alusrca = 1'b1;
            c.alusrcb = SRCB_B;
            c.aluop   = ALU_RTYPE;
         end
         ST_ALUWB: begin
            c.regdst   = 1'b1;
            c.regwrite = 1'b1;
         end
         ST_BRANCH: begin
            c.alusrca  = 1'b1;
            c.alusrcb  = SRCB_B;
            c.pcsource = PCSRC_ALUOUT;
            if (cls == CLS_BNE) begin
               c.aluop         = ALU_BNE;
               c.pcwritecondne = 1'b1;
            end else begin
               c.aluop       = ALU_BEQ;
               c.pcwritecond = 1'b1;
            end
         end
         ST_JUMP: begin
            c.pcwrite  = 1'b1;
            c.pcsource = PCSRC_JUMP;
            c.aluop    = ALU_JUMP;
         end
         ST_IEXEC: begin
            c.alusrca = 1'b1;
            c.alusrcb = SRCB_IMM;
            c.aluop   = imm_aluop;
         end
         ST_IWB: begin
            c.regwrite = 1'b1;
         end
         default: begin
            c = ctrl_t'({CTRL_W{1'b0}});
         end
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multicycle_control_fsm_op_decode.sv
// ---------------------------------------------------------------------------
// mc_op_decode : combinational opcode classifier.
//   op        in  6  opcode (IR[31:26])
//   cls       out    instruction class steering the sequencer
//   imm_aluop out 4  ALUOp for I-type arithmetic/logic (ALU_ADD otherwise)
//   legal     out 1  opcode is supported (NOP counts as legal)
// ---------------------------------------------------------------------------
module mc_op_decode
   import mips_defs::*;
(
   input  logic [5:0] op,
   output op_class_e  cls,
   output logic [3:0] imm_aluop,
   output logic       legal
);

   // Opcode to class / immediate ALU operation lookup
   always_comb begin
      cls       = CLS_ILLEGAL;
      imm_aluop = ALU_ADD;
      case (op)
         OP_RTYPE: cls = CLS_RTYPE;
         OP_LW:    cls = CLS_LW;
         OP_SW:    cls = CLS_SW;
         OP_BEQ:   cls = CLS_BEQ;
         OP_BNE:   cls = CLS_BNE;
         OP_J:     cls = CLS_J;
         OP_NOP:   cls = CLS_NOP;
         OP_ADDI:  begin cls = CLS_IMM; imm_aluop = ALU_ADDI;  end
         OP_ADDIU: begin cls = CLS_IMM; imm_aluop = ALU_ADDIU; end
         OP_ANDI:  begin cls = CLS_IMM; imm_aluop = ALU_ANDI;  end
         OP_ORI:   begin cls = CLS_IMM; imm_aluop = ALU_ORI;   end
         OP_XORI:  begin cls = CLS_IMM; imm_aluop = ALU_XORI;  end
         OP_SLTI:  begin cls = CLS_IMM; imm_aluop = ALU_SLTI;  end
         OP_SLTIU: begin cls = CLS_IMM; imm_aluop = ALU_SLTIU; end
         default:  begin cls = CLS_ILLEGAL; imm_aluop = ALU_ADD; end
      endcase
      legal = (cls != CLS_ILLEGAL);
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm : main sequencer of the multi-cycle MIPS datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// Moore control strobes for the shared memory, ALU and IR/MDR/A/B/ALUOut.
//   Clk, Reset (sync, active-high)  clocking / reset
//   Op        in  6  opcode, only consulted in DECODE
//   MemReady  in  1  memory finishes the current access this cycle
//   PCWrite/PCWriteCond/PCWriteCondNe/IorD/MemRead/MemWrite/IRWrite/
//   MemtoReg/RegDst/RegWrite/ALUSrcA/ALUSrcB/ALUOp/PCSource  control strobes
//   IllegalOp out 1  single-cycle pulse in DECODE for an unsupported opcode
//   State     out STATE_W  current state (debug)
// ---------------------------------------------------------------------------
module multicycle_control_fsm
   import mips_defs::*;
#(
   parameter int MEM_HANDSHAKE = 1,
   parameter int STATE_W       = 4
)(
   input  logic               Clk,
   input  logic               Reset,
   input  logic [5:0]         Op,
   input  logic               MemReady,
   output logic               PCWrite,
   output logic               PCWriteCond,
   output logic               PCWriteCondNe,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               MemtoReg,
   output logic               RegDst,
   output logic               RegWrite,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [3:0]         ALUOp,
   output logic [1:0]         PCSource,
   output logic               IllegalOp,
   output logic [STATE_W-1:0] State
);

   state_e     state_r;
   state_e     state_next_s;
   logic [5:0] op_q_r;
   logic [5:0] op_sel_s;
   ctrl_t      ctrl_r;
   ctrl_t      ctrl_next_s;
   op_class_e  cls_s;
   logic [3:0] imm_aluop_s;
   logic       legal_s;
   logic       mem_ready_s;

   assign mem_ready_s = (MEM_HANDSHAKE != 0) ? MemReady : 1'b1;

   // Opcode in effect: live Op while decoding, the latched copy afterwards.
   // This is also exactly what op_q holds after the next edge.
   always_comb begin
      if (state_r == ST_DECODE) begin
         op_sel_s = Op;
      end else begin
         op_sel_s = op_q_r;
      end
   end

   mc_op_decode u_op_decode (
      .op        (op_sel_s),
      .cls       (cls_s),
      .imm_aluop (imm_aluop_s),
      .legal     (legal_s)
   );

   // Next-state selection; memory states hold until the access completes
   always_comb begin
      state_next_s = ST_FETCH;
      case (state_r)
         ST_FETCH:  state_next_s = mem_ready_s ? ST_DECODE : ST_FETCH;
         ST_DECODE: begin
            case (cls_s)
               CLS_LW, CLS_SW:   state_next_s = ST_MEMADR;
               CLS_RTYPE:        state_next_s = ST_EXEC;
               CLS_BEQ, CLS_BNE: state_next_s = ST_BRANCH;
               CLS_J:            state_next_s = ST_JUMP;
               CLS_IMM:          state_next_s = ST_IEXEC;
               default:          state_next_s = ST_FETCH;
            endcase
         end
         ST_MEMADR: state_next_s = (cls_s == CLS_LW) ? ST_MEMRD : ST_MEMWR;
         ST_MEMRD:  state_next_s = mem_ready_s ? ST_MEMWB : ST_MEMRD;
         ST_MEMWB:  state_next_s = ST_FETCH;
         ST_MEMWR:  state_next_s = mem_ready_s ? ST_FETCH : ST_MEMWR;
         ST_EXEC:   state_next_s = ST_ALUWB;
         ST_ALUWB:  state_next_s = ST_FETCH;
         ST_BRANCH: state_next_s = ST_FETCH;
         ST_JUMP:   state_next_s = ST_FETCH;
         ST_IEXEC:  state_next_s = ST_IWB;
         ST_IWB:    state_next_s = ST_FETCH;
         default:   state_next_s = ST_FETCH;
      endcase
   end

   // Strobes for the state about to be entered, so they come out of a register
   assign ctrl_next_s = ctrl_for_state(state_next_s, cls_s, imm_aluop_s);

   // State, latched opcode and registered strobe set
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r <= ST_FETCH;
         op_q_r  <= 6'b000000;
         ctrl_r  <= ctrl_for_state(ST_FETCH, CLS_NOP, ALU_ADD);
      end else begin
         state_r <= state_next_s;
         op_q_r  <= op_sel_s;
         ctrl_r  <= ctrl_next_s;
      end
   end

   // Output drive: Reset kills every strobe at once; fetch loads wait for memory
   always_comb begin
      if (Reset) begin
         PCWrite       = 1'b0;
         PCWriteCond   = 1'b0;
         PCWriteCondNe = 1'b0;
         IorD          = 1'b0;
         MemRead       = 1'b0;
         MemWrite      = 1'b0;
         IRWrite       = 1'b0;
         MemtoReg      = 1'b0;
         RegDst        = 1'b0;
         RegWrite      = 1'b0;
         ALUSrcA       = 1'b0;
         ALUSrcB       = 2'b00;
         ALUOp         = 4'b0000;
         PCSource      = 2'b00;
         IllegalOp     = 1'b0;
      end else begin
         PCWrite       = ctrl_r.pcwrite & (~ctrl_r.fetch_gate | mem_ready_s);
         PCWriteCond   = ctrl_r.pcwritecond;
         PCWriteCondNe = ctrl_r.pcwritecondne;
         IorD          = ctrl_r.iord;
         MemRead       = ctrl_r.memread;
         MemWrite      = ctrl_r.memwrite;
         IRWrite       = ctrl_r.irwrite & mem_ready_s;
         MemtoReg      = ctrl_r.memtoreg;
         RegDst        = ctrl_r.regdst;
         RegWrite      = ctrl_r.regwrite;
         ALUSrcA       = ctrl_r.alusrca;
         ALUSrcB       = ctrl_r.alusrcb;
         ALUOp         = ctrl_r.aluop;
         PCSource      = ctrl_r.pcsource;
         IllegalOp     = (state_r == ST_DECODE) & ~legal_s;
      end
   end

   assign State = STATE_W'(state_r);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

   logic       Clk = 1'b0;
   logic       Reset;
   logic [5:0] Op;
   logic       MemReady;
   logic       PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite;
   logic       IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp;
   logic [1:0] ALUSrcB, PCSource;
   logic [3:0] ALUOp;
   logic [3:0] State;

   always #5 Clk = ~Clk;

   multicycle_control_fsm #(.MEM_HANDSHAKE(1), .STATE_W(4)) dut (
      .Clk(Clk), .Reset(Reset), .Op(Op), .MemReady(MemReady),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCWriteCondNe(PCWriteCondNe),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
      .IllegalOp(IllegalOp), .State(State)
   );

   typedef struct packed {
      logic [3:0] st;
      logic pcw, pcwc, pcwcne, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
      logic [1:0] asb;
      logic [3:0] aluop;
      logic [1:0] pcs;
      logic ill;
   } obs_t;

   obs_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   logic [5:0] legal_ops [14] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                  6'b000101, 6'b000010, 6'b001000, 6'b001001,
                                  6'b001100, 6'b001101, 6'b001110, 6'b001010,
                                  6'b001011, 6'b110110};

   function automatic logic is_legal(logic [5:0] op);
      for (int i = 0; i < 14; i++) if (legal_ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [3:0] imm_alu(logic [5:0] op);
      case (op)
         6'b001000: return 4'b0100;
         6'b001001: return 4'b0101;
         6'b001100: return 4'b0110;
         6'b001101: return 4'b0111;
         6'b001110: return 4'b1000;
         6'b001010: return 4'b1001;
         6'b001011: return 4'b1010;
         default:   return 4'b0000;
      endcase
   endfunction

   // Reference: strobes for step number st of instruction op, from the rules
   function automatic obs_t expect_obs(int st, logic [5:0] op, logic rdy, logic rst);
      obs_t e;
      e = '0;
      e.st = 4'(st);
      if (rst) return e;
      case (st)
         0: begin e.mrd = 1'b1; e.asb = 2'b01; e.irw = rdy; e.pcw = rdy; end
         1: begin e.asb = 2'b11; e.ill = !is_legal(op); end
         2: begin e.asa = 1'b1; e.asb = 2'b10; end
         3: begin e.iord = 1'b1; e.mrd = 1'b1; end
         4: begin e.m2r = 1'b1; e.rw = 1'b1; end
         5: begin e.iord = 1'b1; e.mwr = 1'b1; end
         6: begin e.asa = 1'b1; e.aluop = 4'b0010; end
         7: begin e.rdst = 1'b1; e.rw = 1'b1; end
         8: begin
            e.asa = 1'b1; e.pcs = 2'b01;
            if (op == 6'b000100) begin e.aluop = 4'b0001; e.pcwc = 1'b1; end
            else begin e.aluop = 4'b1011; e.pcwcne = 1'b1; end
         end
         9:  begin e.pcw = 1'b1; e.pcs = 2'b10; e.aluop = 4'b1100; end
         10: begin e.asa = 1'b1; e.asb = 2'b10; e.aluop = imm_alu(op); end
         11: begin e.rw = 1'b1; end
         default: e = '0;
      endcase
      return e;
   endfunction

   // Drive one cycle and queue its expected response
   task automatic step(input int st, input logic [5:0] iop, input logic rdy, input logic rst);
      @(posedge Clk);
      #1;
      Reset    = rst;
      MemReady = rdy;
      Op       = (st == 1) ? iop : 6'($urandom);
      sb_q.push_back(expect_obs(st, iop, rdy, rst));
   endtask

   // One instruction: fw fetch waits, mw memory waits, optional reset at step abort_at
   task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input int abort_at);
      int   sts[$];
      logic rdys[$];
      for (int i = 0; i < fw; i++) begin sts.push_back(0); rdys.push_back(1'b0); end
      sts.push_back(0); rdys.push_back(1'b1);
      sts.push_back(1); rdys.push_back(1'($urandom));
      case (op)
         6'b000000: begin sts.push_back(6); sts.push_back(7); rdys.push_back(1'($urandom)); rdys.push_back(1'($urandom)); end
         6'b100011, 6'b101011: begin
            sts.push_back(2); rdys.push_back(1'($urandom));
            for (int i = 0; i < mw; i++) begin
               sts.push_back(op == 6'b100011 ? 3 : 5); rdys.push_back(1'b0);
            end
            sts.push_back(op == 6'b100011 ? 3 : 5); rdys.push_back(1'b1);
            if (op == 6'b100011) begin sts.push_back(4); rdys.push_back(1'($urandom)); end
         end
         6'b000100, 6'b000101: begin sts.push_back(8); rdys.push_back(1'($urandom)); end
         6'b000010: begin sts.push_back(9); rdys.push_back(1'($urandom)); end
         default: begin
            if (imm_alu(op) != 4'b0000) begin
               sts.push_back(10); sts.push_back(11);
               rdys.push_back(1'($urandom)); rdys.push_back(1'($urandom));
            end
         end
      endcase
      for (int k = 0; k < sts.size(); k++) begin
         step(sts[k], op, rdys[k], k == abort_at);
         if (k == abort_at) break;
      end
   endtask

   // Monitor: compare every presented cycle against the scoreboard
   initial begin
      obs_t e, a;
      forever begin
         @(negedge Clk);
         cyc++;
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            a.st = State; a.pcw = PCWrite; a.pcwc = PCWriteCond; a.pcwcne = PCWriteCondNe;
            a.iord = IorD; a.mrd = MemRead; a.mwr = MemWrite; a.irw = IRWrite;
            a.m2r = MemtoReg; a.rdst = RegDst; a.rw = RegWrite; a.asa = ALUSrcA;
            a.asb = ALUSrcB; a.aluop = ALUOp; a.pcs = PCSource; a.ill = IllegalOp;
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL ctrl cyc=%0d state got=%0d exp=%0d strobes got=%h exp=%h",
                        cyc, a.st, e.st, a, e);
            end
         end
      end
   end

   initial begin
      logic [5:0] op;
      int fw, mw, ab;
      Reset = 1'b1; MemReady = 1'b1; Op = 6'b000000;
      for (int i = 0; i < 3; i++) step(0, 6'b000000, 1'b1, 1'b1);
      // directed sequences
      run_instr(6'b000000, 0, 0, -1);   // RTYPE 0,1,6,7
      run_instr(6'b100011, 0, 2, -1);   // LW with two MEMRD waits
      run_instr(6'b000101, 0, 0, -1);   // BNE
      run_instr(6'b000100, 1, 0, -1);   // BEQ with a fetch wait
      run_instr(6'b001101, 0, 0, -1);   // ORI
      run_instr(6'b111111, 0, 0, -1);   // illegal
      run_instr(6'b110110, 0, 0, -1);   // NOP
      run_instr(6'b000010, 0, 0, -1);   // J
      run_instr(6'b101011, 1, 3, 5);    // SW, reset during a MEMWR wait
      run_instr(6'b001011, 0, 0, -1);   // SLTIU right after the abort
      // randomized
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 4) == 0) op = 6'($urandom);
         else op = legal_ops[$urandom_range(0, 13)];
         fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         mw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
         ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : -1;
         run_instr(op, fw, mw, ab);
      end
      // drain the scoreboard with a bounded wait
      for (int i = 0; i < 4 && sb_q.size() != 0; i++) @(negedge Clk);
      @(negedge Clk);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain left=%0d need=0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
